pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter/rotator.
- Takes one WIDTH-bit operand per cycle, plus a shift amount and an operation code.
- Uses one log2 stage per pipeline register and a valid/ready handshake on both sides.
- Used in the datapath wherever a variable rotate or shift is needed at full clock rate.
- Successor to the 4-bit combinational rotator: generalised width, five operations, registered and stall-able.

Parameters:
- WIDTH, 32: data width. Must be a power of two and at least 2; otherwise elaboration fails.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Input beat valid.
- in_ready  out  1  Block can accept an input beat this cycle.
- in_data  in  WIDTH  Operand.
- in_shamt  in  SHW  Shift/rotate amount, 0..WIDTH-1.
- in_op  in  3  Operation code (see Behaviour).
- out_valid  out  1  Result beat valid.
- out_ready  in  1  Downstream accepts the result.
- out_data  out  WIDTH  Result.
- out_err  out  1  The op code of this beat was reserved.

Behaviour:
- Reset:
  - Applied on a clk edge while rst=1.
  - Clears every stage valid bit, every stage data/op/shamt register, out_data, out_valid and out_err to 0.
  - Beats in flight at reset are discarded; no partial result appears.
- Op codes (shared package):
  - 000 ROR: rotate right.
  - 001 ROL: rotate left.
  - 010 SRL: logical right, zero fill.
  - 011 SLL: logical left, zero fill.
  - 100 SRA: arithmetic right, fills with in_data[WIDTH-1].
  - 101..111 reserved: out_data = in_data unchanged, out_err = 1.
- Datapath:
  - Left ops are implemented as bit-reverse, then the right op, then bit-reverse.
  - The reverse flag and fill bit are computed at entry and carried down the pipe with the beat.
  - Stage k (k = 0..SHW-1) shifts right by 2^k when shamt bit k = 1, filling vacated positions with the rotated-in bits (rotate ops) or the fill bit (shift ops).
  - in_shamt = 0 gives a pass-through for every op.
- Latency:
  - SHW register stages.
  - A beat accepted at edge t appears on out_data/out_valid after edge t+SHW, provided no stall occurs.
  - Throughput is one beat per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its contents; out_data and out_valid stay stable until out_ready.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - Simultaneous out_ready and new input in the same cycle: both transfers happen, with no bubble.
  - in_data, in_shamt and in_op are ignored when in_valid=0.
- out_data while out_valid=0: holds its last value; it is not required to be 0 except after reset.
- Ordering: results leave in acceptance order. No reordering or dropping.

Decomposition:
- Package barrel_pkg holds:
  - The op-code localparams OP_ROR, OP_ROL, OP_SRL, OP_SLL, OP_SRA.
  - The function is_left(op).
  - The function is_reserved(op).
  - A bit-reverse function parameterised by WIDTH.
- Sub-module shifter_stage:
  - Parameters WIDTH and DIST.
  - Contains one conditional right shift/rotate by DIST, plus its valid/data/shamt/flag register with hold-on-stall.
  - Instantiated SHW times with a generate loop.
- The top level contains the entry decode (reverse and fill), the exit reverse, and the handshake logic.

Test Plan:
- Rotate/shift values (WIDTH=8, out_ready=1):
  - in_data=8'hB1, shamt=3, ROR -> 8'h36 after 3 cycles.
  - Same input, ROL -> 8'h8D.
  - SRL -> 8'h16.
  - SLL -> 8'h88.
  - SRA -> 8'hF6.
- Boundaries (WIDTH=8):
  - shamt=0 for all five ops on 8'h5A -> 8'h5A.
  - shamt=7 ROR on 8'h01 -> 8'h02.
  - SRA shamt=7 on 8'h80 -> 8'hFF.
  - op=3'b110 on 8'h3C -> out_data 8'h3C with out_err=1.
- Back-to-back streaming (WIDTH=8): 20 random beats, in_valid held high, out_ready=1 -> out_valid continuously high from cycle 3 on, results match a reference model in order.
- Backpressure (WIDTH=8):
  - out_ready=0 for 5 cycles while streaming -> in_ready=0 during the stall, out_data stable, no beat lost or duplicated.
  - Release together with a new input in the same cycle -> both transfers occur.
- Reset mid-operation (WIDTH=8):
  - Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and out_data=0 on the next cycle.
  - None of the pre-reset beats ever appear.
  - The first post-reset beat appears after 3 cycles.
- Width sweep: repeat random checking at WIDTH=2, 4 and 64 -> latency equals SHW, and all ops match the model.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared op codes, per-beat flags and helpers for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Widest operand the reverse helper handles; callers zero-extend and truncate.
  localparam int BREV_W = 256;

  typedef struct packed {
    logic rev;   // beat was bit-reversed at entry (left op)
    logic fill;  // bit shifted into vacated positions
    logic rot;   // vacated positions take the rotated-out bits
    logic err;   // reserved op code
  } flags_t;

  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_SRA;
  endfunction

  function automatic logic [BREV_W-1:0] bit_reverse(input logic [BREV_W-1:0] d,
                                                    input int width);
    logic [BREV_W-1:0] r;
    r = '0;
    for (int i = 0; i < BREV_W; i++)
      if (i < width) r[i[7:0]] = d[8'(width - 1 - i)];
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One log2 step: conditional right shift/rotate by DIST, then a stall-able register.
module shifter_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_data,
  input  logic [SHW-1:0]   src_shamt,
  input  flags_t           src_fl,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   shamt,
  output flags_t           fl
);

  localparam int K = $clog2(DIST);

  logic [DIST-1:0]  ins;
  logic [WIDTH-1:0] shifted;

  assign ins     = src_fl.rot ? src_data[DIST-1:0] : {DIST{src_fl.fill}};
  assign shifted = src_shamt[K] ? {ins, src_data[WIDTH-1:DIST]} : src_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      data  <= '0;
      shamt <= '0;
      fl    <= '0;
    end else if (en) begin
      vld   <= src_vld;
      data  <= shifted;
      shamt <= src_shamt;
      fl    <= src_fl;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined shift/rotate: entry decode, SHW shift stages, registered output.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [SHW:0]                vld_pipe;
  logic [SHW:0][WIDTH-1:0]     data_pipe;
  logic [SHW:0][SHW-1:0]       sh_pipe;
  flags_t [SHW:0]              fl_pipe;

  logic             left, rsv;
  logic [WIDTH-1:0] in_rev, out_rev;

  assign left   = is_left(in_op);
  assign rsv    = is_reserved(in_op);
  assign in_rev = WIDTH'(bit_reverse(BREV_W'(in_data), WIDTH));

  // Left ops ride the right-shift datapath between two bit reversals;
  // reserved ops pass through untouched by forcing a zero shift.
  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = left ? in_rev : in_data;
  assign sh_pipe[0]   = rsv ? '0 : in_shamt;
  assign fl_pipe[0]   = '{rev:  left,
                          fill: (in_op == OP_SRA) & in_data[WIDTH-1],
                          rot:  (in_op == OP_ROR) || (in_op == OP_ROL),
                          err:  rsv};

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shifter_stage #(.WIDTH(WIDTH), .DIST(1 << k), .SHW(SHW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .src_vld   (vld_pipe[k]),
      .src_data  (data_pipe[k]),
      .src_shamt (sh_pipe[k]),
      .src_fl    (fl_pipe[k]),
      .vld       (vld_pipe[k+1]),
      .data      (data_pipe[k+1]),
      .shamt     (sh_pipe[k+1]),
      .fl        (fl_pipe[k+1])
    );
  end

  assign out_rev = WIDTH'(bit_reverse(BREV_W'(data_pipe[SHW]), WIDTH));

  // out_data only loads on a valid beat so it holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_pipe[SHW];
      if (vld_pipe[SHW]) begin
        out_data <= fl_pipe[SHW].rev ? out_rev : data_pipe[SHW];
        out_err  <= fl_pipe[SHW].err;
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{sh_pipe[SHW], fl_pipe[SHW].fill, fl_pipe[SHW].rot};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: WIDTH=8 directed/stream/stall/reset tests plus WIDTH=2,4,64 random sweeps.
module tb_pipelined_barrel_shifter;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          t;
    logic        lat;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic [2:0] op;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endfunction

  // Reference: bit-by-bit definition of each op, independent of the stage structure.
  function automatic logic [63:0] model(input logic [63:0] d, input int sh,
                                        input logic [2:0] op, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        3'd0:    r[i] = d[(i + sh) % w];
        3'd1:    r[i] = d[(i - sh + w) % w];
        3'd2:    r[i] = (i + sh < w) ? d[i + sh] : 1'b0;
        3'd3:    r[i] = (i >= sh) ? d[i - sh] : 1'b0;
        3'd4:    r[i] = (i + sh < w) ? d[i + sh] : d[w - 1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // ---------------- WIDTH=8 instance ----------------
  logic       rst = 1, rst_sw = 1;
  logic       in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [7:0] in_data = '0, out_data;
  logic [2:0] in_shamt = '0, in_op = '0;

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  exp_t q[$];
  exp_t e_m;
  logic acc = 0;

  always @(negedge clk) begin
    acc = in_valid && in_ready && !rst;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("w8_spurious_out", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("w8_data", 64'(out_data), e_m.data);
        chk("w8_err", 64'(out_err), 64'(e_m.err));
        if (e_m.lat) chk("w8_latency", 64'(cyc - e_m.t), 3);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic [2:0] op,
                      input logic [7:0] exp, input logic experr, input logic lat);
    exp_t e;
    in_valid = 1; in_data = d; in_shamt = sh; in_op = op;
    for (int n = 0; n < 64; n++) begin
      @(posedge clk); #1;
      if (acc) begin
        e.data = 64'(exp); e.err = experr; e.t = cyc; e.lat = lat;
        q.push_back(e);
        return;
      end
    end
    chk("w8_send_timeout", 0, 1);
  endtask

  task automatic send_rand(input logic lat);
    logic [7:0] d;
    logic [2:0] sh, op;
    d  = 8'($urandom());
    sh = 3'($urandom_range(0, 7));
    op = 3'($urandom_range(0, 7));
    send(d, sh, op, 8'(model(64'(d), int'(sh), op, 8)), op > 3'd4, lat);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    in_valid = 0;
    for (int n = 0; n < 200 && q.size() != 0; n++) begin @(posedge clk); #1; end
    chk("w8_drain", 64'(q.size()), 0);
  endtask

  // ---------------- width sweep instances ----------------
  logic [2:0] sweep_done = '0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 2 : (gi == 1) ? 4 : 64;
    localparam int S = $clog2(W);

    logic         iv = 0, ir, ov, orr = 1, oe, acc_s = 0;
    logic [W-1:0] id = '0, od;
    logic [S-1:0] ish = '0;
    logic [2:0]   iop = '0;
    exp_t qs[$];
    exp_t es;

    pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rst_sw), .in_valid(iv), .in_ready(ir), .in_data(id),
      .in_shamt(ish), .in_op(iop), .out_valid(ov), .out_ready(orr),
      .out_data(od), .out_err(oe)
    );

    always @(negedge clk) begin
      acc_s = iv && ir && !rst_sw;
      if (!rst_sw && ov && orr) begin
        if (qs.size() == 0) chk($sformatf("w%0d_spurious_out", W), 1, 0);
        else begin
          es = qs.pop_front();
          chk($sformatf("w%0d_data", W), 64'(od), es.data);
          chk($sformatf("w%0d_err", W), 64'(oe), 64'(es.err));
          if (es.lat) chk($sformatf("w%0d_latency", W), 64'(cyc - es.t), 64'(S));
        end
      end
    end

    initial begin
      int   sent;
      exp_t e;
      sent = 0;
      wait (!rst_sw);
      @(posedge clk); #1;
      for (int it = 0; it < 600 && sent < 40; it++) begin
        if (iv && acc_s) begin
          e.data = model(64'(id), int'(ish), iop, W);
          e.err  = iop > 3'd4;
          e.t    = cyc;
          e.lat  = (sent == 0);
          qs.push_back(e);
          sent++;
          iv = 0;
        end
        orr = (it < S + 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (!iv && sent < 40 && (sent == 0 || $urandom_range(0, 3) != 0)) begin
          iv  = 1;
          id  = W'({$urandom(), $urandom()});
          ish = S'($urandom_range(0, W - 1));
          iop = 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
      end
      iv = 0; orr = 1;
      for (int n = 0; n < 200 && qs.size() != 0; n++) begin @(posedge clk); #1; end
      chk($sformatf("w%0d_drain", W), 64'(qs.size()), 0);
      chk($sformatf("w%0d_sent", W), 64'(sent), 40);
      sweep_done[gi] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  vec_t tab[14];

  initial begin
    tab = '{
      '{8'hB1, 3'd3, 3'd0, 8'h36, 1'b0}, '{8'hB1, 3'd3, 3'd1, 8'h8D, 1'b0},
      '{8'hB1, 3'd3, 3'd2, 8'h16, 1'b0}, '{8'hB1, 3'd3, 3'd3, 8'h88, 1'b0},
      '{8'hB1, 3'd3, 3'd4, 8'hF6, 1'b0}, '{8'h5A, 3'd0, 3'd0, 8'h5A, 1'b0},
      '{8'h5A, 3'd0, 3'd1, 8'h5A, 1'b0}, '{8'h5A, 3'd0, 3'd2, 8'h5A, 1'b0},
      '{8'h5A, 3'd0, 3'd3, 8'h5A, 1'b0}, '{8'h5A, 3'd0, 3'd4, 8'h5A, 1'b0},
      '{8'h01, 3'd7, 3'd0, 8'h02, 1'b0}, '{8'h80, 3'd7, 3'd4, 8'hFF, 1'b0},
      '{8'h3C, 3'd5, 3'd6, 8'h3C, 1'b1}, '{8'h3C, 3'd0, 3'd7, 8'h3C, 1'b1}
    };

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_err", 64'(out_err), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    rst = 0; rst_sw = 0;

    foreach (tab[i]) send(tab[i].d, tab[i].sh, tab[i].op, tab[i].exp, tab[i].err, 1'b1);
    for (int i = 0; i < 20; i++) send_rand(1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 25; i++) send_rand(1'b0);
      end
      begin
        repeat (6) begin @(posedge clk); #1; end
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(out_valid), 1);
          chk("stall_in_ready", 64'(in_ready), 0);
          if (q.size() != 0) chk("stall_hold", 64'(out_data), q[0].data);
          else chk("stall_queue", 0, 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        chk("release_both_xfer", {62'd0, out_valid, in_valid && in_ready}, 64'd3);
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send_rand(1'b0);
    in_valid = 0;
    rst = 1;
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_out_valid", 64'(out_valid), 0);
    chk("rstmid_out_data", 64'(out_data), 0);
    chk("rstmid_out_err", 64'(out_err), 0);
    @(posedge clk); #1;
    idle(8);
    send(8'hB1, 3'd3, 3'd2, 8'h16, 1'b0, 1'b1);
    drain();

    for (int n = 0; n < 5000 && sweep_done != 3'b111; n++) @(posedge clk);
    chk("sweep_done", 64'(sweep_done), 64'h7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
